conv_layer_stream: RTL and testbench

- Parametrised successor of the fixed 8-bit-in / 32-channel streaming convolution layer.
- Accepts one unsigned pixel per valid_in beat, raster order, single input channel, frame IMG_W x IMG_H.
- Applies OUT_CH parallel KxK kernels (stride 1, no padding) plus per-channel bias and optional ReLU.
- Emits all channels as one packed vector per valid window; sits between the pixel source and the pooling/next-layer stage.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_layer_stream_line_window.sv | 74 +++++++
 rtl/conv_layer_stream.sv | 124 ++++++++++++
 tb/tb_conv_layer_stream.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared defaults and address/size helpers for the streaming convolution layer.
package conv_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_W_W    = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_K      = 3;
    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_OUT_CH = 32;

    // Coefficient map: each channel owns K*K taps followed by its bias.
    function automatic int coef_addr(input int ch, input int tap, input int k);
        return ch * (k * k + 1) + tap;
    endfunction

    function automatic int outputs_per_frame(input int img_w, input int img_h, input int k);
        return (img_w - k + 1) * (img_h - k + 1);
    endfunction
endpackage

// File: rtl/conv_layer_stream_line_window.sv
// Raster line buffers, KxK sliding window and row/col tracking for a single-channel pixel stream.
module conv_line_window
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int K      = DEF_K,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [DATA_W-1:0]         data_in,
    output logic [K*K*DATA_W-1:0]     win_flat,
    output logic                      win_vld_p0,
    output logic                      win_last_p0,
    output logic                      frame_active
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [DATA_W-1:0] lb  [K-1][IMG_W];
    logic [DATA_W-1:0] win [K][K];

    // Stage p0: window shifts in the accepted pixel; strobes mark a complete window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row         <= '0;
            col         <= '0;
            win_vld_p0  <= 1'b0;
            win_last_p0 <= 1'b0;
            for (int m = 0; m < K - 1; m++)
                for (int n = 0; n < IMG_W; n++)
                    lb[m][n] <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win[i][j] <= '0;
        end else begin
            win_vld_p0  <= valid_in && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
            win_last_p0 <= valid_in && (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
            if (valid_in) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // lb[m] tail holds the pixel (m+1) rows above the incoming one.
                lb[0][0] <= data_in;
                for (int m = 1; m < K - 1; m++)
                    lb[m][0] <= lb[m-1][IMG_W-1];
                for (int m = 0; m < K - 1; m++)
                    for (int n = 1; n < IMG_W; n++)
                        lb[m][n] <= lb[m][n-1];
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K - 1; j++)
                        win[i][j] <= win[i][j+1];
                win[K-1][K-1] <= data_in;
                for (int i = 0; i < K - 1; i++)
                    win[i][K-1] <= lb[K-2-i][IMG_W-1];
            end
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_row
        for (genvar j = 0; j < K; j++) begin : g_col
            assign win_flat[(i*K+j)*DATA_W +: DATA_W] = win[i][j];
        end
    end

    assign frame_active = (row != '0) || (col != '0);
endmodule

// File: rtl/conv_layer_stream.sv
// Streaming KxK convolution: OUT_CH parallel MACs over a shared window, bias, optional ReLU.
module conv_layer_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int W_W    = DEF_W_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int K      = DEF_K,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int OUT_CH = DEF_OUT_CH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                valid_in,
    input  logic [DATA_W-1:0]                   data_in,
    input  logic                                relu_en,
    input  logic                                w_we,
    input  logic [$clog2(OUT_CH*(K*K+1))-1:0]   w_addr,
    input  logic [W_W-1:0]                      w_data,
    output logic                                valid_out,
    output logic [OUT_CH*ACC_W-1:0]             data_out,
    output logic                                frame_done,
    output logic                                busy
);
    localparam int NTAP = K * K + 1;
    localparam int AW   = $clog2(OUT_CH * NTAP);

    logic signed [W_W-1:0]    coef [OUT_CH][NTAP];
    logic [K*K*DATA_W-1:0]    win_flat;
    logic                     vld_p0, last_p0, relu_p0, frame_active;
    logic                     vld_p1, last_p1, relu_p1;
    logic                     coef_wr_ok;

    function automatic logic signed [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] px,
                                                        input logic signed [W_W-1:0] w);
        logic signed [ACC_W-1:0] px_s;
        logic signed [ACC_W-1:0] w_s;
        px_s = {{(ACC_W-DATA_W){1'b0}}, px};
        w_s  = {{(ACC_W-W_W){w[W_W-1]}}, w};
        return px_s * w_s;
    endfunction

    function automatic logic signed [ACC_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] x,
                                                           input logic en);
        return (en && x[ACC_W-1]) ? '0 : x;
    endfunction

    conv_line_window #(
        .DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) u_window (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .win_flat(win_flat), .win_vld_p0(vld_p0), .win_last_p0(last_p0),
        .frame_active(frame_active)
    );

    // Coefficients may only change when no window is in flight and no frame is open.
    assign coef_wr_ok = w_we && !busy && !vld_p0 && !vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < OUT_CH; c++)
                for (int t = 0; t < NTAP; t++)
                    coef[c][t] <= '0;
        end else if (coef_wr_ok) begin
            for (int c = 0; c < OUT_CH; c++)
                for (int t = 0; t < NTAP; t++)
                    if (w_addr == AW'(coef_addr(c, t, K)))
                        coef[c][t] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relu_p0    <= 1'b0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            relu_p1    <= 1'b0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (valid_in)
                relu_p0 <= relu_en;
            vld_p1     <= vld_p0;
            last_p1    <= last_p0;
            relu_p1    <= relu_p0;
            valid_out  <= vld_p1;
            frame_done <= last_p1;
            // A back-to-back frame has already moved the counters off the origin.
            busy       <= valid_in || (last_p1 ? frame_active : busy);
        end
    end

    for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
        logic signed [ACC_W-1:0] mac_sum;
        logic signed [ACC_W-1:0] bias_ext;
        logic signed [ACC_W-1:0] sum_p1;
        logic signed [ACC_W-1:0] out_p2;

        always_comb begin
            mac_sum = '0;
            for (int t = 0; t < K * K; t++)
                mac_sum = mac_sum + mul_ext(win_flat[t*DATA_W +: DATA_W], coef[c][t]);
        end

        assign bias_ext = {{(ACC_W-W_W){coef[c][K*K][W_W-1]}}, coef[c][K*K]};

        // Stage p1: registered tap sum. Stage p2: bias, ReLU, output hold.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_p1 <= '0;
                out_p2 <= '0;
            end else begin
                if (vld_p0)
                    sum_p1 <= mac_sum;
                if (vld_p1)
                    out_p2 <= relu_clamp(sum_p1 + bias_ext, relu_p1);
            end
        end

        assign data_out[c*ACC_W +: ACC_W] = out_p2;
    end
endmodule

// File: tb/tb_conv_layer_stream.sv
// Randomised self-checking bench for conv_layer_stream on a 5x5 frame, 3x3 kernel, 2 channels.
module tb_conv_layer_stream;
    localparam int DATA_W = 8, W_W = 8, ACC_W = 32, K = 3;
    localparam int IMG_W = 5, IMG_H = 5, OUT_CH = 2, AW = 5, NPIX = 25, NT = K*K+1;

    logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, relu_en = 1'b0, w_we = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [AW-1:0] w_addr = '0;
    logic [W_W-1:0] w_data = '0;
    logic valid_out, frame_done, busy;
    logic [OUT_CH*ACC_W-1:0] data_out;

    conv_layer_stream #(
        .DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W), .K(K),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_CH(OUT_CH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .relu_en(relu_en), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .valid_out(valid_out), .data_out(data_out), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, edge_n = 0, fd_count = 0;
    int mcoef [OUT_CH][NT];
    int pix [NPIX];
    bit rel [NPIX];
    int acc_edge [NPIX];
    logic [63:0] cap_d[$];
    int cap_e[$];
    bit cap_fd[$];
    int exp_d0[$], exp_d1[$], exp_e[$];
    bit exp_fd[$];

    always @(posedge clk) begin
        edge_n++;
        #1;
        if (valid_out) begin
            cap_d.push_back(data_out);
            cap_e.push_back(edge_n);
            cap_fd.push_back(frame_done);
        end
        if (frame_done) fd_count++;
    end

    // Reference: direct KxK dot product over the frame, bias, then ReLU of the completing beat.
    function automatic int model(input int ch, input int r, input int c);
        int s;
        s = mcoef[ch][K*K];
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += pix[(r-K+1+i)*IMG_W + (c-K+1+j)] * mcoef[ch][i*K+j];
        if (rel[r*IMG_W+c] && s < 0) s = 0;
        return s;
    endfunction

    task automatic push_exp();
        for (int r = K-1; r < IMG_H; r++)
            for (int c = K-1; c < IMG_W; c++) begin
                exp_d0.push_back(model(0, r, c));
                exp_d1.push_back(model(1, r, c));
                exp_e.push_back(acc_edge[r*IMG_W+c] + 2);
                exp_fd.push_back(r == IMG_H-1 && c == IMG_W-1);
            end
    endtask

    task automatic clear_all();
        cap_d.delete(); cap_e.delete(); cap_fd.delete();
        exp_d0.delete(); exp_d1.delete(); exp_e.delete(); exp_fd.delete();
        fd_count = 0;
    endtask

    task automatic write_coef(input int addr, input int val);
        w_we = 1'b1; w_addr = AW'(addr); w_data = W_W'(val);
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic set_ch(input int ch, input int w, input int b, input bit rnd);
        int v;
        for (int t = 0; t < NT; t++) begin
            v = rnd ? int'($urandom_range(0, 255)) - 128 : ((t == K*K) ? b : w);
            write_coef(ch*NT + t, v);
            mcoef[ch][t] = v;
        end
    endtask

    task automatic drive(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                valid_in = 1'b0; data_in = DATA_W'($urandom); relu_en = 1'($urandom);
                @(posedge clk); #1;
            end
            valid_in = 1'b1; data_in = DATA_W'(pix[i]); relu_en = rel[i];
            @(posedge clk); #1;
            acc_edge[i] = edge_n;
            valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", frame_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ones();
        set_ch(0, 1, 0, 0); set_ch(1, 1, 0, 0);
        for (int i = 0; i < NPIX; i++) begin pix[i] = 1; rel[i] = 0; end
        clear_all();
        drive(0, 0, 0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ones_busy_hi got=%b want=1", busy); end
        drive(1, NPIX-1, 0); push_exp(); drain();
        total++; if (cap_d.size() != exp_d0.size()) begin bad++; $display("FAIL ones_count got=%0d want=%0d", cap_d.size(), exp_d0.size()); end
        for (int k = 0; k < exp_d0.size() && k < cap_d.size(); k++) begin
            total++;
            if ($signed(cap_d[k][31:0]) !== exp_d0[k] || $signed(cap_d[k][63:32]) !== exp_d1[k] || cap_e[k] !== exp_e[k] || cap_fd[k] !== exp_fd[k]) begin
                bad++; $display("FAIL ones_win%0d got=%0d/%0d@%0d fd=%0d want=%0d/%0d@%0d fd=%0d", k, $signed(cap_d[k][31:0]), $signed(cap_d[k][63:32]), cap_e[k], cap_fd[k], exp_d0[k], exp_d1[k], exp_e[k], exp_fd[k]);
            end
        end
        total++; if (fd_count !== 1) begin bad++; $display("FAIL ones_fd_count got=%0d want=1", fd_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ones_busy_lo got=%b want=0", busy); end
    endtask

    task automatic test_ramp();
        set_ch(0, 1, 0, 0); set_ch(1, 0, 0, 1);
        for (int i = 0; i < NPIX; i++) begin pix[i] = i; rel[i] = 1'($urandom); end
        clear_all();
        drive(0, NPIX-1, 0); push_exp(); drain();
        total++; if (cap_d.size() != exp_d0.size()) begin bad++; $display("FAIL ramp_count got=%0d want=%0d", cap_d.size(), exp_d0.size()); end
        for (int k = 0; k < exp_d0.size() && k < cap_d.size(); k++) begin
            total++;
            if ($signed(cap_d[k][31:0]) !== exp_d0[k] || $signed(cap_d[k][63:32]) !== exp_d1[k] || cap_e[k] !== exp_e[k] || cap_fd[k] !== exp_fd[k]) begin
                bad++; $display("FAIL ramp_win%0d got=%0d/%0d@%0d want=%0d/%0d@%0d", k, $signed(cap_d[k][31:0]), $signed(cap_d[k][63:32]), cap_e[k], exp_d0[k], exp_d1[k], exp_e[k]);
            end
        end
        if (cap_d.size() == 9) begin
            total++; if ($signed(cap_d[0][31:0]) !== 54) begin bad++; $display("FAIL ramp_first got=%0d want=54", $signed(cap_d[0][31:0])); end
            total++; if ($signed(cap_d[8][31:0]) !== 162) begin bad++; $display("FAIL ramp_last got=%0d want=162", $signed(cap_d[8][31:0])); end
        end
    endtask

    task automatic test_relu();
        set_ch(0, 1, 0, 0); set_ch(1, -1, 5, 0);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NPIX; i++) begin pix[i] = 10; rel[i] = 1'(pass); end
            clear_all();
            drive(0, NPIX-1, 0); drain();
            total++; if (cap_d.size() != 9) begin bad++; $display("FAIL relu%0d_count got=%0d want=9", pass, cap_d.size()); end
            for (int k = 0; k < cap_d.size(); k++) begin
                total++;
                if ($signed(cap_d[k][63:32]) !== (pass ? 0 : -85) || $signed(cap_d[k][31:0]) !== 90) begin
                    bad++; $display("FAIL relu%0d_win%0d got=%0d/%0d want=90/%0d", pass, k, $signed(cap_d[k][31:0]), $signed(cap_d[k][63:32]), pass ? 0 : -85);
                end
            end
        end
    endtask

    task automatic test_gaps();
        set_ch(0, 1, 0, 0); set_ch(1, 1, 0, 0);
        for (int i = 0; i < NPIX; i++) begin pix[i] = 1; rel[i] = 1'($urandom); end
        clear_all();
        drive(0, NPIX-1, 3); push_exp(); drain();
        total++; if (cap_d.size() != exp_d0.size()) begin bad++; $display("FAIL gaps_count got=%0d want=%0d", cap_d.size(), exp_d0.size()); end
        for (int k = 0; k < exp_d0.size() && k < cap_d.size(); k++) begin
            total++;
            if ($signed(cap_d[k][31:0]) !== exp_d0[k] || $signed(cap_d[k][63:32]) !== exp_d1[k] || cap_e[k] !== exp_e[k] || cap_fd[k] !== exp_fd[k]) begin
                bad++; $display("FAIL gaps_win%0d got=%0d/%0d@%0d want=%0d/%0d@%0d", k, $signed(cap_d[k][31:0]), $signed(cap_d[k][63:32]), cap_e[k], exp_d0[k], exp_d1[k], exp_e[k]);
            end
        end
        total++; if (fd_count !== 1) begin bad++; $display("FAIL gaps_fd_count got=%0d want=1", fd_count); end
    endtask

    task automatic test_coef_busy();
        set_ch(0, 1, 0, 0); set_ch(1, 2, -3, 0);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NPIX; i++) begin pix[i] = int'($urandom_range(0, 255)); rel[i] = 0; end
            clear_all();
            drive(0, 4, 0);
            if (f == 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL coef_busy_hi got=%b want=1", busy); end
                write_coef(0, 7);
            end
            drive(5, NPIX-1, 1); push_exp(); drain();
            total++; if (cap_d.size() != exp_d0.size()) begin bad++; $display("FAIL coef%0d_count got=%0d want=%0d", f, cap_d.size(), exp_d0.size()); end
            for (int k = 0; k < exp_d0.size() && k < cap_d.size(); k++) begin
                total++;
                if ($signed(cap_d[k][31:0]) !== exp_d0[k] || $signed(cap_d[k][63:32]) !== exp_d1[k]) begin
                    bad++; $display("FAIL coef%0d_win%0d got=%0d/%0d want=%0d/%0d", f, k, $signed(cap_d[k][31:0]), $signed(cap_d[k][63:32]), exp_d0[k], exp_d1[k]);
                end
            end
            if (f == 0) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL coef_busy_lo got=%b want=0", busy); end
                write_coef(0, 7);   mcoef[0][0] = 7;
                write_coef(19, -20); mcoef[1][K*K] = -20;
                write_coef(20, 99);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_ch(0, 1, 0, 0); set_ch(1, 1, 0, 0);
        for (int i = 0; i < NPIX; i++) begin pix[i] = 1; rel[i] = 0; end
        clear_all();
        drive(0, 12, 0);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_async got=busy%b/vld%b want=0/0", busy, valid_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < OUT_CH; c++) for (int t = 0; t < NT; t++) mcoef[c][t] = 0;
        drive(0, NPIX-1, 0); push_exp(); drain();
        total++; if (cap_d.size() != exp_d0.size()) begin bad++; $display("FAIL rstmid_count got=%0d want=%0d", cap_d.size(), exp_d0.size()); end
        for (int k = 0; k < exp_d0.size() && k < cap_d.size(); k++) begin
            total++;
            if ($signed(cap_d[k][31:0]) !== exp_d0[k] || $signed(cap_d[k][63:32]) !== exp_d1[k] || cap_e[k] !== exp_e[k]) begin
                bad++; $display("FAIL rstmid_win%0d got=%0d/%0d@%0d want=%0d/%0d@%0d", k, $signed(cap_d[k][31:0]), $signed(cap_d[k][63:32]), cap_e[k], exp_d0[k], exp_d1[k], exp_e[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_ch(0, 0, 0, 1); set_ch(1, 0, 0, 1);
        clear_all();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NPIX; i++) begin pix[i] = int'($urandom_range(0, 255)); rel[i] = 1'($urandom); end
            drive(0, NPIX-1, 0);
            push_exp();
        end
        drain();
        total++; if (cap_d.size() != 18) begin bad++; $display("FAIL b2b_count got=%0d want=18", cap_d.size()); end
        for (int k = 0; k < exp_d0.size() && k < cap_d.size(); k++) begin
            total++;
            if ($signed(cap_d[k][31:0]) !== exp_d0[k] || $signed(cap_d[k][63:32]) !== exp_d1[k] || cap_e[k] !== exp_e[k] || cap_fd[k] !== exp_fd[k]) begin
                bad++; $display("FAIL b2b_win%0d got=%0d/%0d@%0d fd=%0d want=%0d/%0d@%0d fd=%0d", k, $signed(cap_d[k][31:0]), $signed(cap_d[k][63:32]), cap_e[k], cap_fd[k], exp_d0[k], exp_d1[k], exp_e[k], exp_fd[k]);
            end
        end
        total++; if (fd_count !== 2) begin bad++; $display("FAIL b2b_fd_count got=%0d want=2", fd_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_lo got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_relu();
        test_gaps();
        test_coef_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
